// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - opcodes, opcode classes and sequencer state encoding
package processor_pkg;

  localparam int DIV_TIMEOUT_DEFAULT = 32;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_DIV   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_BEQZ  = 4'hA;
  localparam logic [3:0] OP_JMP   = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_DIV,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  // Encoding is exported verbatim on the debug state port.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'h0,
    ST_FETCH    = 4'h1,
    ST_DECODE   = 4'h2,
    ST_EXEC     = 4'h3,
    ST_DIV_WAIT = 4'h4,
    ST_MEM      = 4'h5,
    ST_WB       = 4'h6,
    ST_HALT     = 4'h7,
    ST_ERROR    = 4'h8
  } state_e;

endpackage

// File: rtl/opcode_class_decoder.sv
// rtl/opcode_class_decoder.sv - combinational opcode to instruction-class map
module opcode_class_decoder
  import processor_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_e  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: op_class = CLS_ALU;
      OP_DIV:   op_class = CLS_DIV;
      OP_LOAD:  op_class = CLS_LOAD;
      OP_STORE: op_class = CLS_STORE;
      OP_BEQZ:  op_class = CLS_BRANCH;
      OP_JMP:   op_class = CLS_JUMP;
      OP_NOP:   op_class = CLS_NOP;
      OP_HALT:  op_class = CLS_HALT;
      default:  op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM
module multicycle_sequencer
  import processor_pkg::*;
#(
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             instr_valid,
  input  logic [3:0]       opcode,
  input  logic             div_done,
  input  logic             zero_flag,
  input  logic             error_flag,
  output logic             ir_load,
  output logic             alu_start,
  output logic             mem_signal_write,
  output logic             reg_signal_write,
  output logic             pc_enable,
  output logic             pc_sel,
  output logic             halted,
  output logic             fault,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] DIV_LAST = 8'(DIV_TIMEOUT - 1);

  state_e    state_q, state_d;
  op_class_e dec_class, cls_q;
  logic [7:0] div_cnt;

  opcode_class_decoder u_decoder (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  // The class is captured in DECODE so later phases do not depend on the IR holding still.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_NOP;
      div_cnt <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) cls_q <= dec_class;
      div_cnt <= (state_q == ST_DIV_WAIT) ? div_cnt + 8'd1 : 8'd0;
      if (pc_enable) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_d          = state_q;
    ir_load          = 1'b0;
    alu_start        = 1'b0;
    mem_signal_write = 1'b0;
    reg_signal_write = 1'b0;
    pc_enable        = 1'b0;
    pc_sel           = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        ir_load = instr_valid;
        if (instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (dec_class)
          CLS_ILLEGAL: state_d = ST_ERROR;
          CLS_HALT:    state_d = ST_HALT;
          default:     state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_ALU: begin
            alu_start = 1'b1;
            state_d   = ST_WB;
          end
          CLS_DIV: begin
            alu_start = 1'b1;
            state_d   = ST_DIV_WAIT;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default: begin
            pc_enable = 1'b1;
            pc_sel    = (cls_q == CLS_JUMP) || ((cls_q == CLS_BRANCH) && zero_flag);
            state_d   = ST_FETCH;
          end
        endcase
      end
      // A result arriving in the last allowed cycle still beats the timeout.
      ST_DIV_WAIT: begin
        if (div_done)                 state_d = ST_WB;
        else if (div_cnt >= DIV_LAST) state_d = ST_ERROR;
      end
      ST_MEM: begin
        if (cls_q == CLS_STORE) begin
          mem_signal_write = 1'b1;
          pc_enable        = 1'b1;
          state_d          = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        reg_signal_write = !error_flag;
        pc_enable        = !error_flag;
        state_d          = error_flag ? ST_ERROR : ST_FETCH;
      end
      ST_HALT, ST_ERROR: state_d = state_q;
      default: state_d = ST_ERROR;
    endcase
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALT);
  assign fault  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;
  import processor_pkg::*;

  localparam logic [7:0] S_IR  = 8'h80;
  localparam logic [7:0] S_ALU = 8'h40;
  localparam logic [7:0] S_MW  = 8'h20;
  localparam logic [7:0] S_RW  = 8'h10;
  localparam logic [7:0] S_PE  = 8'h08;
  localparam logic [7:0] S_PS  = 8'h04;
  localparam logic [7:0] S_H   = 8'h02;
  localparam logic [7:0] S_F   = 8'h01;

  typedef struct {
    bit          which;
    string       tag;
    logic [3:0]  op;
    logic        st, idv, zf, dd, ef, rs;
    logic [3:0]  exp_state;
    logic [7:0]  exp_strb;
    logic [15:0] exp_ret;
  } entry_t;

  logic clock = 1'b0;
  logic reset = 1'b1, start = 1'b0, instr_valid = 1'b0, div_done = 1'b0;
  logic zero_flag = 1'b0, error_flag = 1'b0;
  logic [3:0] opcode = 4'h0;

  logic m_ir, m_alu, m_mw, m_rw, m_pe, m_ps, m_h, m_f;
  logic [3:0]  m_state;
  logic [15:0] m_ret;
  logic s_ir, s_alu, s_mw, s_rw, s_pe, s_ps, s_h, s_f;
  logic [3:0] s_state;
  logic [3:0] s_ret;

  entry_t exp_q[$];
  int     mret[2];
  int     errors = 0;
  int     checks = 0;

  always #5 clock = ~clock;

  multicycle_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .instr_valid(instr_valid), .opcode(opcode),
    .div_done(div_done), .zero_flag(zero_flag), .error_flag(error_flag),
    .ir_load(m_ir), .alu_start(m_alu), .mem_signal_write(m_mw), .reg_signal_write(m_rw),
    .pc_enable(m_pe), .pc_sel(m_ps), .halted(m_h), .fault(m_f), .state(m_state), .retired(m_ret)
  );

  multicycle_sequencer #(.DIV_TIMEOUT(4), .CNT_W(4)) dut_s (
    .clock(clock), .reset(reset), .start(start), .instr_valid(instr_valid), .opcode(opcode),
    .div_done(div_done), .zero_flag(zero_flag), .error_flag(error_flag),
    .ir_load(s_ir), .alu_start(s_alu), .mem_signal_write(s_mw), .reg_signal_write(s_rw),
    .pc_enable(s_pe), .pc_sel(s_ps), .halted(s_h), .fault(s_f), .state(s_state), .retired(s_ret)
  );

  task automatic push(input bit which, input string tag, input logic [3:0] op, input logic st,
                      input logic idv, input logic zf, input logic dd, input logic ef,
                      input logic rs, input logic [3:0] exp_state, input logic [7:0] exp_strb);
    entry_t e;
    e.which = which; e.tag = tag; e.op = op; e.st = st; e.idv = idv; e.zf = zf;
    e.dd = dd; e.ef = ef; e.rs = rs; e.exp_state = exp_state; e.exp_strb = exp_strb;
    e.exp_ret = 16'(mret[which]);
    exp_q.push_back(e);
    if (rs) begin
      mret[0] = 0;
      mret[1] = 0;
    end else if ((exp_strb & S_PE) != 0) begin
      mret[which] = (mret[which] + 1) & (which ? 32'hF : 32'hFFFF);
    end
  endtask

  task automatic push_start(input bit which);
    push(which, "start", 4'h0, 1, 1, 0, 0, 0, 0, ST_IDLE, 8'h00);
  endtask

  // Expected trace of one non-divide instruction, from FETCH through its last phase.
  task automatic push_instr(input bit which, input logic [3:0] op, input logic zf, input logic wb_ef);
    logic [7:0] wb_strb;
    wb_strb = wb_ef ? 8'h00 : (S_RW | S_PE);
    push(which, "fetch", op, 0, 1, zf, 0, 0, 0, ST_FETCH, S_IR);
    push(which, "decode", op, 0, 1, zf, 0, 0, 0, ST_DECODE, 8'h00);
    case (op)
      OP_LOAD: begin
        push(which, "exec_ld", op, 0, 1, zf, 0, 0, 0, ST_EXEC, 8'h00);
        push(which, "mem_ld", op, 0, 1, zf, 0, 0, 0, ST_MEM, 8'h00);
        push(which, "wb_ld", op, 0, 1, zf, 0, wb_ef, 0, ST_WB, wb_strb);
      end
      OP_STORE: begin
        push(which, "exec_st", op, 0, 1, zf, 0, 0, 0, ST_EXEC, 8'h00);
        push(which, "mem_st", op, 0, 1, zf, 0, 0, 0, ST_MEM, S_MW | S_PE);
      end
      OP_NOP: push(which, "exec_nop", op, 0, 1, zf, 0, 0, 0, ST_EXEC, S_PE);
      OP_JMP: push(which, "exec_jmp", op, 0, 1, zf, 0, 0, 0, ST_EXEC, S_PE | S_PS);
      OP_BEQZ: push(which, "exec_beqz", op, 0, 1, zf, 0, 0, 0, ST_EXEC, zf ? (S_PE | S_PS) : S_PE);
      default: begin
        push(which, "exec_alu", op, 0, 1, zf, 0, 0, 0, ST_EXEC, S_ALU);
        push(which, "wb_alu", op, 0, 1, zf, 0, wb_ef, 0, ST_WB, wb_strb);
      end
    endcase
  endtask

  task automatic step(output entry_t e, output logic [3:0] o_st, output logic [7:0] o_strb,
                      output logic [15:0] o_ret);
    e = exp_q.pop_front();
    start = e.st; instr_valid = e.idv; opcode = e.op; zero_flag = e.zf;
    div_done = e.dd; error_flag = e.ef; reset = e.rs;
    @(negedge clock);
    if (e.which) begin
      o_st = s_state; o_strb = {s_ir, s_alu, s_mw, s_rw, s_pe, s_ps, s_h, s_f};
      o_ret = {12'h000, s_ret};
    end else begin
      o_st = m_state; o_strb = {m_ir, m_alu, m_mw, m_rw, m_pe, m_ps, m_h, m_f};
      o_ret = m_ret;
    end
    @(posedge clock);
    #1;
    reset = 1'b0; start = 1'b0; div_done = 1'b0; error_flag = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; div_done = 1'b0; error_flag = 1'b0; zero_flag = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mret[0] = 0;
    mret[1] = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; instr_valid = 1'b1; opcode = OP_ADD;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks += 6;
    if (m_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", m_state, ST_IDLE); end
    if ({m_ir, m_alu, m_mw, m_rw, m_pe, m_ps, m_h, m_f} !== 8'h00) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000000", {m_ir, m_alu, m_mw, m_rw, m_pe, m_ps, m_h, m_f});
    end
    if (m_ret !== 16'h0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", m_ret); end
    if (s_state !== ST_IDLE) begin errors++; $display("FAIL reset_state_s: got %0d expected %0d", s_state, ST_IDLE); end
    if ({s_ir, s_alu, s_mw, s_rw, s_pe, s_ps, s_h, s_f} !== 8'h00) begin
      errors++; $display("FAIL reset_strobes_s: got %b expected 00000000", {s_ir, s_alu, s_mw, s_rw, s_pe, s_ps, s_h, s_f});
    end
    if (s_ret !== 4'h0) begin errors++; $display("FAIL reset_retired_s: got %0d expected 0", s_ret); end
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic test_alu();
    entry_t e; logic [3:0] o_st; logic [7:0] o_strb; logic [15:0] o_ret;
    do_reset();
    push_start(0);
    push(0, "fetch_stall", OP_ADD, 0, 0, 0, 0, 0, 0, ST_FETCH, 8'h00);
    push_instr(0, OP_ADD, 0, 0);
    push_instr(0, OP_XOR, 1, 0);
    push_instr(0, OP_MUL, 0, 1);
    push(0, "wb_err_fault", OP_MUL, 1, 1, 0, 0, 0, 0, ST_ERROR, S_F);
    push(0, "fault_sticky", OP_MUL, 1, 1, 0, 0, 0, 0, ST_ERROR, S_F);
    while (exp_q.size() > 0) begin
      step(e, o_st, o_strb, o_ret);
      checks += 3;
      if (o_st !== e.exp_state) begin errors++; $display("FAIL alu/%s state: got %0d expected %0d", e.tag, o_st, e.exp_state); end
      if (o_strb !== e.exp_strb) begin errors++; $display("FAIL alu/%s strobes: got %b expected %b", e.tag, o_strb, e.exp_strb); end
      if (o_ret !== e.exp_ret) begin errors++; $display("FAIL alu/%s retired: got %0d expected %0d", e.tag, o_ret, e.exp_ret); end
    end
  endtask

  task automatic test_store_load();
    entry_t e; logic [3:0] o_st; logic [7:0] o_strb; logic [15:0] o_ret;
    do_reset();
    push_start(0);
    push_instr(0, OP_STORE, 0, 0);
    push_instr(0, OP_LOAD, 0, 0);
    push_instr(0, OP_STORE, 1, 0);
    push(0, "fetch_end", OP_NOP, 0, 0, 0, 0, 0, 0, ST_FETCH, 8'h00);
    while (exp_q.size() > 0) begin
      step(e, o_st, o_strb, o_ret);
      checks += 3;
      if (o_st !== e.exp_state) begin errors++; $display("FAIL mem/%s state: got %0d expected %0d", e.tag, o_st, e.exp_state); end
      if (o_strb !== e.exp_strb) begin errors++; $display("FAIL mem/%s strobes: got %b expected %b", e.tag, o_strb, e.exp_strb); end
      if (o_ret !== e.exp_ret) begin errors++; $display("FAIL mem/%s retired: got %0d expected %0d", e.tag, o_ret, e.exp_ret); end
    end
  endtask

  task automatic test_div();
    entry_t e; logic [3:0] o_st; logic [7:0] o_strb; logic [15:0] o_ret;
    do_reset();
    push_start(0);
    push(0, "fetch", OP_DIV, 0, 1, 0, 0, 0, 0, ST_FETCH, S_IR);
    push(0, "decode", OP_DIV, 0, 1, 0, 0, 0, 0, ST_DECODE, 8'h00);
    push(0, "exec_div", OP_DIV, 0, 1, 0, 0, 0, 0, ST_EXEC, S_ALU);
    for (int i = 1; i <= 5; i++)
      push(0, "div_wait", OP_DIV, 0, 1, 0, (i == 5), 0, 0, ST_DIV_WAIT, 8'h00);
    push(0, "wb_div", OP_DIV, 0, 1, 0, 0, 0, 0, ST_WB, S_RW | S_PE);
    push(0, "fetch_next", OP_DIV, 0, 0, 0, 0, 0, 0, ST_FETCH, 8'h00);
    while (exp_q.size() > 0) begin
      step(e, o_st, o_strb, o_ret);
      checks += 3;
      if (o_st !== e.exp_state) begin errors++; $display("FAIL div/%s state: got %0d expected %0d", e.tag, o_st, e.exp_state); end
      if (o_strb !== e.exp_strb) begin errors++; $display("FAIL div/%s strobes: got %b expected %b", e.tag, o_strb, e.exp_strb); end
      if (o_ret !== e.exp_ret) begin errors++; $display("FAIL div/%s retired: got %0d expected %0d", e.tag, o_ret, e.exp_ret); end
    end
  endtask

  task automatic test_div_timeout();
    entry_t e; logic [3:0] o_st; logic [7:0] o_strb; logic [15:0] o_ret;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      push_start(1);
      push(1, "fetch", OP_DIV, 0, 1, 0, 0, 0, 0, ST_FETCH, S_IR);
      push(1, "decode", OP_DIV, 0, 1, 0, 0, 0, 0, ST_DECODE, 8'h00);
      push(1, "exec_div", OP_DIV, 0, 1, 0, 0, 0, 0, ST_EXEC, S_ALU);
      for (int i = 1; i <= 4; i++)
        push(1, "div_wait", OP_DIV, 0, 1, 0, (pass == 1) && (i == 4), 0, 0, ST_DIV_WAIT, 8'h00);
      if (pass == 0) begin
        push(1, "timeout_fault", OP_DIV, 1, 1, 0, 1, 0, 0, ST_ERROR, S_F);
        push(1, "fault_sticky", OP_DIV, 1, 1, 0, 0, 0, 0, ST_ERROR, S_F);
      end else begin
        push(1, "last_cycle_wb", OP_DIV, 0, 1, 0, 0, 0, 0, ST_WB, S_RW | S_PE);
        push(1, "fetch_next", OP_DIV, 0, 0, 0, 0, 0, 0, ST_FETCH, 8'h00);
      end
      while (exp_q.size() > 0) begin
        step(e, o_st, o_strb, o_ret);
        checks += 3;
        if (o_st !== e.exp_state) begin errors++; $display("FAIL divto%0d/%s state: got %0d expected %0d", pass, e.tag, o_st, e.exp_state); end
        if (o_strb !== e.exp_strb) begin errors++; $display("FAIL divto%0d/%s strobes: got %b expected %b", pass, e.tag, o_strb, e.exp_strb); end
        if (o_ret !== e.exp_ret) begin errors++; $display("FAIL divto%0d/%s retired: got %0d expected %0d", pass, e.tag, o_ret, e.exp_ret); end
      end
    end
  endtask

  task automatic test_branch();
    entry_t e; logic [3:0] o_st; logic [7:0] o_strb; logic [15:0] o_ret;
    do_reset();
    push_start(0);
    push_instr(0, OP_BEQZ, 1, 0);
    push_instr(0, OP_BEQZ, 0, 0);
    push_instr(0, OP_JMP, 0, 0);
    push_instr(0, OP_JMP, 1, 0);
    push_instr(0, OP_NOP, 1, 0);
    push(0, "fetch_end", OP_NOP, 0, 0, 0, 0, 0, 0, ST_FETCH, 8'h00);
    while (exp_q.size() > 0) begin
      step(e, o_st, o_strb, o_ret);
      checks += 3;
      if (o_st !== e.exp_state) begin errors++; $display("FAIL br/%s state: got %0d expected %0d", e.tag, o_st, e.exp_state); end
      if (o_strb !== e.exp_strb) begin errors++; $display("FAIL br/%s strobes: got %b expected %b", e.tag, o_strb, e.exp_strb); end
      if (o_ret !== e.exp_ret) begin errors++; $display("FAIL br/%s retired: got %0d expected %0d", e.tag, o_ret, e.exp_ret); end
    end
  endtask

  task automatic test_faults();
    entry_t e; logic [3:0] o_st; logic [7:0] o_strb; logic [15:0] o_ret;
    for (int sc = 0; sc < 3; sc++) begin
      do_reset();
      push_start(0);
      if (sc == 0) begin
        push(0, "fetch", 4'hD, 0, 1, 0, 0, 0, 0, ST_FETCH, S_IR);
        push(0, "decode_ill", 4'hD, 0, 1, 0, 0, 0, 0, ST_DECODE, 8'h00);
        push(0, "illegal_fault", 4'hD, 1, 1, 0, 0, 0, 0, ST_ERROR, S_F);
      end else if (sc == 1) begin
        push(0, "fetch", OP_HALT, 0, 1, 0, 0, 0, 0, ST_FETCH, S_IR);
        push(0, "decode_halt", OP_HALT, 0, 1, 0, 0, 0, 0, ST_DECODE, 8'h00);
        push(0, "halted", OP_HALT, 1, 1, 0, 0, 0, 0, ST_HALT, S_H);
        push(0, "halt_ign_start", OP_HALT, 1, 1, 0, 0, 0, 0, ST_HALT, S_H);
      end else begin
        push(0, "fetch", OP_ADD, 0, 1, 0, 0, 0, 0, ST_FETCH, S_IR);
        push(0, "decode", OP_ADD, 0, 1, 0, 0, 0, 0, ST_DECODE, 8'h00);
        push(0, "exec", OP_ADD, 0, 1, 0, 0, 0, 0, ST_EXEC, S_ALU);
        push(0, "wb_reset", OP_ADD, 0, 1, 0, 0, 0, 1, ST_WB, S_RW | S_PE);
        push(0, "idle_after_rst", OP_ADD, 0, 1, 0, 0, 0, 0, ST_IDLE, 8'h00);
      end
      while (exp_q.size() > 0) begin
        step(e, o_st, o_strb, o_ret);
        checks += 3;
        if (o_st !== e.exp_state) begin errors++; $display("FAIL flt%0d/%s state: got %0d expected %0d", sc, e.tag, o_st, e.exp_state); end
        if (o_strb !== e.exp_strb) begin errors++; $display("FAIL flt%0d/%s strobes: got %b expected %b", sc, e.tag, o_strb, e.exp_strb); end
        if (o_ret !== e.exp_ret) begin errors++; $display("FAIL flt%0d/%s retired: got %0d expected %0d", sc, e.tag, o_ret, e.exp_ret); end
      end
    end
  endtask

  task automatic test_wrap();
    entry_t e; logic [3:0] o_st; logic [7:0] o_strb; logic [15:0] o_ret;
    do_reset();
    push_start(1);
    for (int i = 0; i < 17; i++) push_instr(1, OP_NOP, 0, 0);
    push(1, "fetch_wrapped", OP_NOP, 0, 0, 0, 0, 0, 0, ST_FETCH, 8'h00);
    while (exp_q.size() > 0) begin
      step(e, o_st, o_strb, o_ret);
      checks += 3;
      if (o_st !== e.exp_state) begin errors++; $display("FAIL wrap/%s state: got %0d expected %0d", e.tag, o_st, e.exp_state); end
      if (o_strb !== e.exp_strb) begin errors++; $display("FAIL wrap/%s strobes: got %b expected %b", e.tag, o_strb, e.exp_strb); end
      if (o_ret !== e.exp_ret) begin errors++; $display("FAIL wrap/%s retired: got %0d expected %0d", e.tag, o_ret, e.exp_ret); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mret[0] = 0;
    mret[1] = 0;
    test_reset();
    test_alu();
    test_store_load();
    test_div();
    test_div_timeout();
    test_branch();
    test_faults();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
